// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared types and constants for the fir_mac_seq engine
package fir_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int WIDTH_DEF     = 16;
    localparam int TAPS_DEF      = 64;
    localparam int ADRLENGTH_DEF = 6;

    // Accumulator wide enough for TAPS full-precision products without overflow.
    function automatic int acc_width(input int width, input int adrlength);
        return 2 * width + adrlength;
    endfunction

    // Half an output LSB in accumulator units; added before the Q-format shift.
    function automatic longint round_const(input int width);
        return longint'(1) << (width - 2);
    endfunction

endpackage

// File: rtl/fir_delay_line.sv
// rtl/fir_delay_line.sv - TAPS-deep sample shift register with addressed tap read
module fir_delay_line
    import fir_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int TAPS      = TAPS_DEF,
    parameter int ADRLENGTH = ADRLENGTH_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 shift_en,
    input  logic [WIDTH-1:0]     din,
    input  logic [ADRLENGTH-1:0] tap_sel,
    output logic [WIDTH-1:0]     tap_data
);

    logic [WIDTH-1:0] taps [TAPS];

    // Newest sample enters tap 0; everything else moves one tap older.
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) begin
                taps[i] <= '0;
            end
        end else if (shift_en) begin
            taps[0] <= din;
            for (int i = 1; i < TAPS; i++) begin
                taps[i] <= taps[i-1];
            end
        end
    end

    // Explicit mux so addresses beyond TAPS-1 read zero rather than undefined storage.
    always_comb begin
        tap_data = '0;
        for (int i = 0; i < TAPS; i++) begin
            if (tap_sel == ADRLENGTH'(i)) begin
                tap_data = taps[i];
            end
        end
    end

endmodule

// File: rtl/fir_mac_seq.sv
// rtl/fir_mac_seq.sv - time-multiplexed FIR MAC engine; FIR_SAT_EN selects output saturation
module fir_mac_seq
    import fir_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int TAPS      = TAPS_DEF,
    parameter int ADRLENGTH = ADRLENGTH_DEF,
    parameter int ACC_W     = acc_width(WIDTH, ADRLENGTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic [ADRLENGTH-1:0] coef_adr,
    input  logic [WIDTH-1:0]     coef_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data
);

    localparam logic signed [ACC_W-1:0] ROUND    = ACC_W'(round_const(WIDTH));
    localparam logic [ADRLENGTH-1:0]    LAST_TAP = ADRLENGTH'(TAPS - 1);

    state_t state, state_nxt;

    logic [ADRLENGTH-1:0]      k, k_nxt;
    logic signed [ACC_W-1:0]   acc, acc_nxt, acc_sum;
    logic signed [ACC_W-1:0]   rnd_sum, shifted;
    logic signed [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]          tap_data;
    logic [WIDTH-1:0]          out_nxt;
    logic                      shift_en;
    logic                      load_out;

    assign shift_en = in_valid && in_ready;

    fir_delay_line #(
        .WIDTH     (WIDTH),
        .TAPS      (TAPS),
        .ADRLENGTH (ADRLENGTH)
    ) u_delay_line (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .din      (in_data),
        .tap_sel  (k),
        .tap_data (tap_data)
    );

    // Product of the current tap and coefficient, added onto the running sum.
    always_comb begin
        prod    = $signed(tap_data) * $signed(coef_data);
        acc_sum = acc + $signed({{(ACC_W - 2*WIDTH){prod[2*WIDTH-1]}}, prod});
    end

    // Round half-up into Q1.15, then either clamp or wrap to the output width.
    always_comb begin
        rnd_sum = acc_sum + ROUND;
        shifted = rnd_sum >>> (WIDTH - 1);
`ifdef FIR_SAT_EN
        if (!((&shifted[ACC_W-1:WIDTH-1]) || !(|shifted[ACC_W-1:WIDTH-1]))) begin
            out_nxt = shifted[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                       : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            out_nxt = WIDTH'(shifted);
        end
`else
        out_nxt = WIDTH'(shifted);
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, handshake outputs and datapath controls.
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        acc_nxt   = acc;
        load_out  = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        coef_adr  = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = MAC;
                    k_nxt     = '0;
                    acc_nxt   = '0;
                end
            end
            MAC: begin
                coef_adr = k;
                acc_nxt  = acc_sum;
                if (k == LAST_TAP) begin
                    state_nxt = OUT;
                    k_nxt     = '0;
                    load_out  = 1'b1;
                end else begin
                    k_nxt = k + 1'b1;
                end
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Tap counter, accumulator and output register; out_data is frozen once loaded.
    always_ff @(posedge clk) begin
        if (!rst) begin
            k        <= '0;
            acc      <= '0;
            out_data <= '0;
        end else begin
            k   <= k_nxt;
            acc <= acc_nxt;
            if (load_out) begin
                out_data <= out_nxt;
            end
        end
    end

endmodule
